// File: rtl/gb_lb_arbiter.sv
// Two-master localbus arbiter: the host owns the bus whenever it strobes; a
// req/ack secondary master (B) is slotted into idle cycles, and read data is routed back by tag.
`timescale 1ns/1ps
module gb_lb_arbiter #(
    parameter int AW           = 24,
    parameter int DW           = 32,
    parameter int READ_DELAY   = 3,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a_addr,
    input  logic          a_write,
    input  logic          a_read,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_write,
    input  logic          b_read,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_busy,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,
    output logic [AW-1:0] lb_addr,
    output logic          lb_write,
    output logic          lb_read,
    output logic [DW-1:0] lb_wdata,
    input  logic [DW-1:0] lb_rdata,
    input  logic          stat_clr,
    output logic          b_starve,
    output logic [15:0]   b_wait_max
);
    localparam logic [15:0] STARVE_LIMIT_W = 16'(STARVE_LIMIT);

    logic          a_strobe;
    logic          issue;
    logic          capture;
    logic          starve_evt;

    logic          pend_q, pend_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [DW-1:0] hold_wdata_q, hold_wdata_d;
    logic          hold_write_q, hold_write_d;

    logic [AW-1:0] lb_addr_q, lb_addr_d;
    logic [DW-1:0] lb_wdata_q, lb_wdata_d;
    logic          lb_write_q, lb_write_d;
    logic          lb_read_q, lb_read_d;
    logic          lb_owner_q, lb_owner_d;   // 1 when the current bus cycle belongs to B
    logic          b_ack_q, b_ack_d;

    logic [READ_DELAY-1:0] tag_v_q, tag_v_d;
    logic [READ_DELAY-1:0] tag_o_q, tag_o_d;
    logic                  tap_v;
    logic                  tap_o;

    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          b_rvalid_q, b_rvalid_d;

    logic [15:0]   wait_q, wait_d;
    logic [15:0]   b_wait_max_q, b_wait_max_d;
    logic          b_starve_q, b_starve_d;

    assign a_strobe = a_write | a_read;
    assign issue    = pend_q & ~a_strobe;
    assign capture  = b_req & ~b_busy & (b_write | b_read);

    // The bus cycle itself counts as in flight before it enters the tag pipe.
    assign b_busy = pend_q | (lb_read_q & lb_owner_q) | (|(tag_v_q & tag_o_q));

    always_comb begin
        pend_d       = pend_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_write_d = hold_write_q;
        if (issue) begin
            pend_d = 1'b0;
        end
        if (capture) begin
            pend_d       = 1'b1;
            hold_addr_d  = b_addr;
            hold_wdata_d = b_wdata;
            hold_write_d = b_write;
        end
    end

    always_comb begin
        lb_addr_d  = lb_addr_q;
        lb_wdata_d = lb_wdata_q;
        lb_write_d = 1'b0;
        lb_read_d  = 1'b0;
        lb_owner_d = 1'b0;
        if (a_strobe) begin
            lb_addr_d  = a_addr;
            lb_wdata_d = a_wdata;
            lb_write_d = a_write;
            lb_read_d  = a_read;
        end else if (pend_q) begin
            lb_addr_d  = hold_addr_q;
            lb_wdata_d = hold_wdata_q;
            lb_write_d = hold_write_q;
            lb_read_d  = ~hold_write_q;
            lb_owner_d = 1'b1;
        end
        b_ack_d = issue;
    end

    generate
        for (genvar gi = 0; gi < READ_DELAY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_v_d[gi] = lb_read_q;
                assign tag_o_d[gi] = lb_owner_q;
            end else begin : g_body
                assign tag_v_d[gi] = tag_v_q[gi-1];
                assign tag_o_d[gi] = tag_o_q[gi-1];
            end
        end
    endgenerate

    assign tap_v = tag_v_q[READ_DELAY-1];
    assign tap_o = tag_o_q[READ_DELAY-1];

    always_comb begin
        a_rvalid_d = tap_v & ~tap_o;
        b_rvalid_d = tap_v & tap_o;
        a_rdata_d  = a_rvalid_d ? lb_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? lb_rdata : b_rdata_q;
    end

    always_comb begin
        wait_d     = wait_q;
        starve_evt = 1'b0;
        if (issue) begin
            wait_d = '0;
        end else if (pend_q && wait_q != 16'hFFFF) begin
            wait_d     = wait_q + 16'd1;
            starve_evt = (wait_d == STARVE_LIMIT_W);
        end
    end

    // A clear coinciding with an issue restarts the maximum from this wait.
    always_comb begin
        b_wait_max_d = b_wait_max_q;
        if (stat_clr) begin
            b_wait_max_d = issue ? wait_q : 16'd0;
        end else if (issue && (wait_q > b_wait_max_q)) begin
            b_wait_max_d = wait_q;
        end
        if (starve_evt) begin
            b_starve_d = 1'b1;
        end else if (stat_clr) begin
            b_starve_d = 1'b0;
        end else begin
            b_starve_d = b_starve_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_write_q <= 1'b0;
            lb_addr_q    <= '0;
            lb_wdata_q   <= '0;
            lb_write_q   <= 1'b0;
            lb_read_q    <= 1'b0;
            lb_owner_q   <= 1'b0;
            b_ack_q      <= 1'b0;
            tag_v_q      <= '0;
            tag_o_q      <= '0;
            a_rdata_q    <= '0;
            a_rvalid_q   <= 1'b0;
            b_rdata_q    <= '0;
            b_rvalid_q   <= 1'b0;
            wait_q       <= '0;
            b_wait_max_q <= '0;
            b_starve_q   <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_write_q <= hold_write_d;
            lb_addr_q    <= lb_addr_d;
            lb_wdata_q   <= lb_wdata_d;
            lb_write_q   <= lb_write_d;
            lb_read_q    <= lb_read_d;
            lb_owner_q   <= lb_owner_d;
            b_ack_q      <= b_ack_d;
            tag_v_q      <= tag_v_d;
            tag_o_q      <= tag_o_d;
            a_rdata_q    <= a_rdata_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rdata_q    <= b_rdata_d;
            b_rvalid_q   <= b_rvalid_d;
            wait_q       <= wait_d;
            b_wait_max_q <= b_wait_max_d;
            b_starve_q   <= b_starve_d;
        end
    end

    assign lb_addr    = lb_addr_q;
    assign lb_wdata   = lb_wdata_q;
    assign lb_write   = lb_write_q;
    assign lb_read    = lb_read_q;
    assign b_ack      = b_ack_q;
    assign a_rdata    = a_rdata_q;
    assign a_rvalid   = a_rvalid_q;
    assign b_rdata    = b_rdata_q;
    assign b_rvalid   = b_rvalid_q;
    assign b_wait_max = b_wait_max_q;
    assign b_starve   = b_starve_q;

endmodule

// File: doc/gb_lb_arbiter.md
Name: gb_lb_arbiter

Overview:
Two-master localbus arbiter that places a secondary on-chip master (boot/config sequencer) on the ghostbus localbus alongside the host (rtefi p2 port).
- The host has absolute priority and is never stalled, because the host port has no backpressure.
- The secondary master uses a req/ack handshake and is granted only in idle bus cycles.
- The arbiter routes fixed-latency read data back to the master that issued each read, and reports starvation of the secondary master.

Parameters:
AW, 24, localbus address width
DW, 32, localbus data width
READ_DELAY, 3, slave read latency in cycles, lb_read to lb_rdata valid (>=1)
STARVE_LIMIT, 1024, B wait cycles that set b_starve (<65535)

Ports:
clk  in  1  localbus clock (lb_clk domain)
rst  in  1  asynchronous reset, active-high
a_addr  in  AW  host address
a_write  in  1  host write strobe
a_read  in  1  host read strobe
a_wdata  in  DW  host write data
a_rdata  out  DW  host read data
a_rvalid  out  1  host read data valid, 1-cycle pulse
b_req  in  1  B command request
b_write  in  1  B command is a write
b_read  in  1  B command is a read
b_addr  in  AW  B address
b_wdata  in  DW  B write data
b_ack  out  1  B command issued on bus, 1-cycle pulse
b_busy  out  1  B command pending or B read in flight
b_rdata  out  DW  B read data
b_rvalid  out  1  B read data valid, 1-cycle pulse
lb_addr  out  AW  bus address (registered)
lb_write  out  1  bus write strobe (registered)
lb_read  out  1  bus read strobe (registered)
lb_wdata  out  DW  bus write data (registered)
lb_rdata  in  DW  bus read data, valid READ_DELAY cycles after lb_read
stat_clr  in  1  clears b_starve and b_wait_max
b_starve  out  1  sticky starvation flag
b_wait_max  out  16  maximum observed B grant wait in cycles, saturating

Behaviour:
Reset:
- Asynchronous reset clears all registered outputs to 0: lb_*, a_rdata, b_rdata, rvalids, b_ack, b_starve, b_wait_max.
- Reset also clears the pending register and the tag pipeline.
- Reads in flight at reset are dropped; no rvalid is issued for them after reset releases.

Host path:
- Each cycle with a_write or a_read high, the arbiter registers a_* onto lb_* the next cycle, passed through verbatim.
- Host latency: a_read at cycle s gives lb_read at s+1 and a_rvalid/a_rdata at s+2+READ_DELAY.

B capture:
- When b_req=1 and b_busy=0, the arbiter captures addr, wdata and type into the hold register and sets pend.
- b_req while b_busy=1 is ignored; B must wait for b_busy low.
- If b_write and b_read are both high, the command is a write.
- If both are low, the request is ignored and pend is not set.

B issue:
- In any cycle with pend=1 and a_write=a_read=0, the arbiter drives the held command onto lb_* the next cycle.
- The same cycle, b_ack pulses and pend clears.
- Simultaneous host strobe and pend: host wins and B stays pending.

Read routing:
- A shift register of depth READ_DELAY carries {valid, owner} per issued bus cycle.
- At the tap, lb_rdata is registered into the owner's rdata and the owner's rvalid pulses.
- Host and B reads may interleave back-to-back; every read returns exactly once to its issuer, in issue order.
- a_rdata and b_rdata hold their value when rvalid is low.

b_busy:
- b_busy = pend OR any B-owned read still in the tag pipe.
- b_busy is not asserted for B writes after b_ack.

Wait and starvation:
- The wait counter increments each cycle pend=1 and no issue occurs, saturating at 16'hFFFF.
- The counter clears on issue.
- On issue, b_wait_max <= max(b_wait_max, wait).
- When wait reaches STARVE_LIMIT, b_starve sets and stays set until stat_clr.
- stat_clr zeroes b_starve and b_wait_max.
- If stat_clr coincides with a new max or starve event, the event wins.

Test Plan:
- Host only: a_read addr 0x000010 at cycle 10, slave returns 0xceceface -> lb_read at 11, a_rvalid with 0xceceface at 15 (READ_DELAY=3); b_rvalid stays 0.
- B idle-bus write: b_req write addr 0x000020 data 0x5a, host idle -> b_ack the following cycle; lb_write/lb_addr 0x20/lb_wdata 0x5a the cycle after capture+1; b_busy drops with the issue.
- Collision: b_req read held pending while host strobes 5 consecutive cycles -> B issued the first idle cycle; b_wait_max=5; b_rdata carries the B slave data and no a_rvalid is generated for it.
- Interleave: host read (0x111), B read (0x222), host read (0x333) on consecutive bus cycles -> a_rvalid, b_rvalid, a_rvalid on consecutive cycles with matching data.
- Starvation: STARVE_LIMIT=8, host strobes continuously for 20 cycles with B pending -> b_starve set at wait 8 and remains set; stat_clr then clears it and b_wait_max returns 0.
- Reset mid-read: assert rst one cycle after lb_read of a B read -> no b_rvalid after release; b_busy=0; a fresh b_req is accepted.
